// File: rtl/cr_cceip_64_sa_snap_ctrl_if.sv
// Readout bus between the snapshot controller and the downstream reader.
// The controller presents one counter per transfer; the reader throttles with rd_ready.
interface cr_cceip_64_sa_snap_ctrl_if #(
    parameter int CNT_W = 50
);
    logic             rd_valid;
    logic             rd_ready;
    logic [5:0]       rd_idx;
    logic [CNT_W-1:0] rd_data;
    logic             rd_last;

    modport master (
        output rd_valid,
        output rd_idx,
        output rd_data,
        output rd_last,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_idx,
        input  rd_data,
        input  rd_last,
        output rd_ready
    );
endinterface

// File: rtl/cr_cceip_64_sa_snap_ctrl.sv
// Snapshot controller for the stats aggregator core.
// Arbitrates software clear, software snapshot and periodic snapshot requests, pulses
// the core's snap/clear inputs, waits for the snapshot to settle, then streams every
// counter out over the readout bus. Dropped snapshot requests are counted as overruns.
module cr_cceip_64_sa_snap_ctrl #(
    parameter int NUM_CNT    = 64,
    parameter int CNT_W      = 50,
    parameter int SETTLE_CYC = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              sw_snap_req,
    input  logic                              sw_clear_req,
    input  logic [31:0]                       period_cfg,
    input  logic [0:NUM_CNT-1][CNT_W-1:0]     sa_snapshot,
    output logic                              sa_snap_o,
    output logic                              sa_clear_o,
    cr_cceip_64_sa_snap_ctrl_if.master        rd,
    output logic                              busy,
    output logic                              snap_done,
    output logic [15:0]                       overrun_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SNAP,
        SETTLE,
        STREAM,
        DONE
    } state_t;

    localparam logic [5:0] LAST_IDX    = 6'(NUM_CNT - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t      state;
    state_t      state_nx;
    logic [3:0]  phase;
    logic [3:0]  phase_nx;
    logic [5:0]  idx;
    logic [5:0]  idx_nx;

    logic        clr_pend;
    logic        sw_pend;
    logic        tmr_pend;
    logic        clr_grant;
    logic        snap_grant;

    logic [31:0] timer;
    logic [31:0] period_q;
    logic        tmr_expire;

    logic        sw_ovr;
    logic        tmr_ovr;
    logic [16:0] ovr_sum;
    logic [15:0] ovr_nx;

    logic        snap_q;
    logic        clear_q;
    logic        valid_q;
    logic        last_q;
    logic        busy_q;
    logic        done_q;

    // The timer only fires once the configured period has been stable for a full interval
    assign tmr_expire = (period_cfg != 32'd0) && (period_cfg == period_q) && (timer == 32'd0);

    // Periodic timer: reloads on a period change or at zero, otherwise counts down
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer    <= 32'd0;
            period_q <= 32'd0;
        end else begin
            period_q <= period_cfg;
            if (period_cfg == 32'd0) begin
                timer <= 32'd0;
            end else if ((period_cfg != period_q) || (timer == 32'd0)) begin
                timer <= period_cfg - 32'd1;
            end else begin
                timer <= timer - 32'd1;
            end
        end
    end

    // Next-state logic: grants from IDLE, fixed-length pulse phases, and the readout walk
    always_comb begin
        state_nx   = state;
        phase_nx   = phase;
        idx_nx     = idx;
        clr_grant  = 1'b0;
        snap_grant = 1'b0;
        case (state)
            IDLE: begin
                if (clr_pend) begin
                    clr_grant = 1'b1;
                    state_nx  = CLR;
                    phase_nx  = 4'd0;
                end else if (sw_pend || tmr_pend) begin
                    snap_grant = 1'b1;
                    state_nx   = SNAP;
                    phase_nx   = 4'd0;
                end
            end
            CLR: begin
                if (phase == 4'd1) begin
                    state_nx = IDLE;
                    phase_nx = 4'd0;
                end else begin
                    phase_nx = phase + 4'd1;
                end
            end
            SNAP: begin
                if (phase == 4'd1) begin
                    state_nx = SETTLE;
                    phase_nx = 4'd0;
                end else begin
                    phase_nx = phase + 4'd1;
                end
            end
            SETTLE: begin
                if (phase == SETTLE_LAST) begin
                    state_nx = STREAM;
                    phase_nx = 4'd0;
                    idx_nx   = 6'd0;
                end else begin
                    phase_nx = phase + 4'd1;
                end
            end
            STREAM: begin
                if (rd.rd_ready) begin
                    if (idx == LAST_IDX) begin
                        state_nx = DONE;
                        idx_nx   = 6'd0;
                    end else begin
                        idx_nx = idx + 6'd1;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                phase_nx = 4'd0;
                idx_nx   = 6'd0;
            end
        endcase
    end

    // State register plus outputs registered from the state being entered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            phase   <= 4'd0;
            idx     <= 6'd0;
            snap_q  <= 1'b0;
            clear_q <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            phase   <= phase_nx;
            idx     <= idx_nx;
            snap_q  <= (state_nx == SNAP);
            clear_q <= (state_nx == CLR);
            valid_q <= (state_nx == STREAM);
            last_q  <= (idx_nx == LAST_IDX);
            busy_q  <= (state_nx != IDLE);
            done_q  <= (state_nx == DONE);
        end
    end

    // A request is dropped only when its flag is already set and not being granted now
    always_comb begin
        sw_ovr  = sw_snap_req & sw_pend & ~snap_grant;
        tmr_ovr = tmr_expire & tmr_pend & ~snap_grant;
        ovr_sum = {1'b0, overrun_cnt} + {15'd0, sw_ovr} + {15'd0, tmr_ovr};
        ovr_nx  = ovr_sum[16] ? 16'hFFFF : ovr_sum[15:0];
    end

    // Pending flags and overrun counter; a grant and a new request in one cycle leave the flag set
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_pend    <= 1'b0;
            sw_pend     <= 1'b0;
            tmr_pend    <= 1'b0;
            overrun_cnt <= 16'd0;
        end else begin
            clr_pend    <= (clr_pend & ~clr_grant) | sw_clear_req;
            sw_pend     <= (sw_pend & ~snap_grant) | sw_snap_req;
            tmr_pend    <= (tmr_pend & ~snap_grant) | tmr_expire;
            overrun_cnt <= ovr_nx;
        end
    end

    assign sa_snap_o   = snap_q;
    assign sa_clear_o  = clear_q;
    assign busy        = busy_q;
    assign snap_done   = done_q;
    assign rd.rd_valid = valid_q;
    assign rd.rd_last  = last_q;
    assign rd.rd_idx   = idx;
    assign rd.rd_data  = sa_snapshot[idx];

endmodule

// File: tb/tb_cr_cceip_64_sa_snap_ctrl.sv
// Self-checking bench for the stats snapshot controller: a directed vector table,
// hand-written multi-cycle scenarios and a randomized run against a transaction-level model.
module tb_cr_cceip_64_sa_snap_ctrl;

    localparam int NUM_CNT    = 64;
    localparam int CNT_W      = 50;
    localparam int SETTLE_CYC = 4;

    logic                          clk;
    logic                          rst_n;
    logic                          sw_snap_req;
    logic                          sw_clear_req;
    logic [31:0]                   period_cfg;
    logic [0:NUM_CNT-1][CNT_W-1:0] snap_arr;
    logic                          sa_snap_o;
    logic                          sa_clear_o;
    logic                          busy;
    logic                          snap_done;
    logic [15:0]                   overrun_cnt;

    cr_cceip_64_sa_snap_ctrl_if #(.CNT_W(CNT_W)) rd_if ();

    cr_cceip_64_sa_snap_ctrl #(
        .NUM_CNT    (NUM_CNT),
        .CNT_W      (CNT_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_snap_req  (sw_snap_req),
        .sw_clear_req (sw_clear_req),
        .period_cfg   (period_cfg),
        .sa_snapshot  (snap_arr),
        .sa_snap_o    (sa_snap_o),
        .sa_clear_o   (sa_clear_o),
        .rd           (rd_if),
        .busy         (busy),
        .snap_done    (snap_done),
        .overrun_cnt  (overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: current operation (0 none, 1 clear, 2 snapshot),
    // cycles spent in it, counters already transferred, request flags, timer age.
    int          m_op;
    int          m_el;
    int          m_xfer;
    bit          m_clr;
    bit          m_sw;
    bit          m_tm;
    logic [31:0] m_per;
    longint      m_age;
    int          m_ovr;

    typedef struct {
        bit        sw_snap;
        bit        sw_clear;
        bit        rd_ready;
        bit [3:0]  exp_ctrl;
        bit [5:0]  exp_idx;
        bit [15:0] exp_ovr;
    } vec_t;

    vec_t        tbl [14];
    logic [31:0] per_tbl [6] = '{32'd0, 32'd1, 32'd2, 32'd5, 32'd37, 32'd150};

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs the DUT sampled on the same edge
    task automatic modelStep();
        bit tm_exp;
        bit g_clr;
        bit g_snap;
        if (!rst_n) begin
            m_op = 0; m_el = 0; m_xfer = 0;
            m_clr = 0; m_sw = 0; m_tm = 0;
            m_per = 32'd0; m_age = 0; m_ovr = 0;
            return;
        end
        tm_exp = 1'b0;
        if (period_cfg != m_per) begin
            m_per = period_cfg;
            m_age = 0;
        end else if (period_cfg != 32'd0) begin
            m_age++;
            if (m_age == longint'(period_cfg)) begin
                tm_exp = 1'b1;
                m_age  = 0;
            end
        end
        g_clr  = 1'b0;
        g_snap = 1'b0;
        case (m_op)
            0: begin
                if (m_clr) begin
                    g_clr = 1'b1; m_op = 1; m_el = 0;
                end else if (m_sw || m_tm) begin
                    g_snap = 1'b1; m_op = 2; m_el = 0; m_xfer = 0;
                end
            end
            1: begin
                if (m_el == 1) m_op = 0;
                else m_el++;
            end
            default: begin
                if (m_xfer == NUM_CNT) m_op = 0;
                else if (m_el < 2 + SETTLE_CYC) m_el++;
                else if (rd_if.rd_ready) m_xfer++;
            end
        endcase
        if (sw_snap_req && m_sw && !g_snap) m_ovr++;
        if (tm_exp && m_tm && !g_snap) m_ovr++;
        if (m_ovr > 65535) m_ovr = 65535;
        m_clr = (m_clr && !g_clr) || sw_clear_req;
        m_sw  = (m_sw && !g_snap) || sw_snap_req;
        m_tm  = (m_tm && !g_snap) || tm_exp;
    endtask

    task automatic checkOutput();
        bit stream;
        stream = (m_op == 2) && (m_el >= 2 + SETTLE_CYC) && (m_xfer < NUM_CNT);
        compare("sa_snap_o", 64'(sa_snap_o), 64'(m_op == 2 && m_el < 2));
        compare("sa_clear_o", 64'(sa_clear_o), 64'(m_op == 1));
        compare("snap_clear_excl", 64'(sa_snap_o & sa_clear_o), 64'(0));
        compare("busy", 64'(busy), 64'(m_op != 0));
        compare("snap_done", 64'(snap_done), 64'(m_op == 2 && m_xfer == NUM_CNT));
        compare("rd_valid", 64'(rd_if.rd_valid), 64'(stream));
        compare("rd_last", 64'(rd_if.rd_last), 64'(stream && m_xfer == NUM_CNT - 1));
        compare("overrun_cnt", 64'(overrun_cnt), 64'(m_ovr));
        if (stream) begin
            compare("rd_idx", 64'(rd_if.rd_idx), 64'(m_xfer));
            compare("rd_data", 64'(rd_if.rd_data), 64'(snap_arr[m_xfer]));
        end
    endtask

    // Drive one cycle of inputs, clock it, step the model and compare everything
    task automatic applyStimulus(input bit rst, input bit sw, input bit clr, input bit rdy);
        rst_n           = rst;
        sw_snap_req     = sw;
        sw_clear_req    = clr;
        rd_if.rd_ready  = rdy;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < 600 && !idle; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
            idle = (m_op == 0) && !m_clr && !m_sw && !m_tm;
        end
        compare("drain_timeout", 64'(idle), 64'(1));
    endtask

    int  n_s, t_s0, t_v, n_x, bad, n_last, n_d, t_d, t_lx, n_rise;
    bit  found, busy_seen, prev_snap;

    initial begin
        rst_n          = 1'b0;
        sw_snap_req    = 1'b0;
        sw_clear_req   = 1'b0;
        period_cfg     = 32'd0;
        rd_if.rd_ready = 1'b0;
        for (int i = 0; i < NUM_CNT; i++) snap_arr[i] = CNT_W'({$urandom, $urandom});

        // Reset values
        doReset();
        compare("reset_outputs", 64'({sa_snap_o, sa_clear_o, rd_if.rd_valid, rd_if.rd_last, busy, snap_done, overrun_cnt}), 64'(0));

        // Clear and snapshot requested together: clear first, then snapshot, then a stalled readout
        tbl[0] = '{1'b1, 1'b1, 1'b1, 4'b0000, 6'd0, 16'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 4'b0110, 6'd0, 16'd0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 4'b0110, 6'd0, 16'd0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 4'b0000, 6'd0, 16'd0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 4'b1010, 6'd0, 16'd0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 4'b1010, 6'd0, 16'd0};
        for (int i = 6; i < 10; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 4'b0010, 6'd0, 16'd0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 4'b0011, 6'd0, 16'd0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 4'b0011, 6'd1, 16'd0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 4'b0011, 6'd1, 16'd0};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 4'b0011, 6'd2, 16'd1};
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, tbl[i].sw_snap, tbl[i].sw_clear, tbl[i].rd_ready);
            compare($sformatf("tbl_ctrl[%0d]", i), 64'({sa_snap_o, sa_clear_o, busy, rd_if.rd_valid}), 64'(tbl[i].exp_ctrl));
            compare($sformatf("tbl_ovr[%0d]", i), 64'(overrun_cnt), 64'(tbl[i].exp_ovr));
            if (tbl[i].exp_ctrl[0]) compare($sformatf("tbl_idx[%0d]", i), 64'(rd_if.rd_idx), 64'(tbl[i].exp_idx));
        end
        drain();

        // Single software snapshot with a free-flowing reader
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        n_s = 0; t_s0 = -1; t_v = -1; n_x = 0; bad = 0; n_last = 0; n_d = 0; t_d = -1; t_lx = -1;
        for (int c = 1; c <= 120; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
            if (sa_snap_o) begin
                n_s++;
                if (t_s0 < 0) t_s0 = c;
            end
            if (rd_if.rd_valid && t_v < 0) t_v = c;
            if (rd_if.rd_last) begin
                n_last++;
                if (rd_if.rd_idx != 6'd63) bad++;
            end
            if (rd_if.rd_valid && rd_if.rd_ready) begin
                if (n_x < NUM_CNT) begin
                    if (rd_if.rd_idx != 6'(n_x)) bad++;
                    if (rd_if.rd_data != snap_arr[n_x]) bad++;
                end
                n_x++;
                t_lx = c;
            end
            if (snap_done) begin
                n_d++;
                t_d = c;
            end
        end
        compare("basic_snap_width", 64'(n_s), 64'(2));
        compare("basic_snap_start", 64'(t_s0), 64'(1));
        compare("basic_settle_gap", 64'(t_v - t_s0), 64'(2 + SETTLE_CYC));
        compare("basic_xfer_count", 64'(n_x), 64'(NUM_CNT));
        compare("basic_seq_errors", 64'(bad), 64'(0));
        compare("basic_last_count", 64'(n_last), 64'(1));
        compare("basic_done_count", 64'(n_d), 64'(1));
        compare("basic_done_after_last", 64'(t_d), 64'(t_lx + 1));

        // Reset in the middle of a stream, with a snapshot request presented during reset
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
            if (rd_if.rd_valid && rd_if.rd_idx == 6'd30) found = 1'b1;
        end
        compare("reach_idx30", 64'(found), 64'(1));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        compare("midstream_rst_outputs", 64'({sa_snap_o, sa_clear_o, rd_if.rd_valid, rd_if.rd_last, busy, snap_done, overrun_cnt}), 64'(0));
        n_d = 0; busy_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
            if (snap_done) n_d++;
            busy_seen |= busy;
        end
        compare("no_done_after_rst", 64'(n_d), 64'(0));
        compare("req_in_rst_ignored", 64'(busy_seen), 64'(0));
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
            found = rd_if.rd_valid;
        end
        compare("restart_seen", 64'(found), 64'(1));
        compare("restart_idx", 64'(rd_if.rd_idx), 64'(0));
        drain();

        // Periodic snapshots every 100 cycles with the reader stalled for 300 cycles
        doReset();
        period_cfg = 32'd100;
        t_s0 = -1; t_v = -1;
        for (int c = 1; c <= 200 && t_v < 0; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            if (sa_snap_o && t_s0 < 0) t_s0 = c;
            if (rd_if.rd_valid) t_v = c;
        end
        compare("timer_first_snap", 64'(t_s0), 64'(102));
        compare("timer_stream_seen", 64'(t_v > 0), 64'(1));
        for (int c = 0; c < 300; c++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        n_d = 0;
        for (int c = 0; c < 100 && n_d == 0; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
            if (snap_done) n_d++;
        end
        compare("stall_stream_done", 64'(n_d), 64'(1));
        compare("stall_overrun_cnt", 64'(overrun_cnt), 64'(2));
        period_cfg = 32'd0;
        n_rise = 0; prev_snap = 1'b0;
        for (int c = 0; c < 300; c++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
            if (sa_snap_o && !prev_snap) n_rise++;
            prev_snap = sa_snap_o;
        end
        compare("stall_followup_snaps", 64'(n_rise), 64'(1));

        // Randomized traffic against the model
        doReset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(199, 0) == 0) period_cfg = per_tbl[$urandom_range(5, 0)];
            applyStimulus($urandom_range(499, 0) != 0, $urandom_range(19, 0) == 0,
                          $urandom_range(39, 0) == 0, $urandom_range(9, 0) < 7);
        end
        period_cfg = 32'd0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cr_cceip_64_sa_snap_ctrl.md
CR_CCEIP_64_SA_SNAP_CTRL -- requirements
Module: cr_cceip_64_sa_snap_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): NUM_CNT, 64, number of stats counters; CNT_W, 50, counter width; SETTLE_CYC, 4, idle cycles between snap-pulse end and the start of readout (legal 1..15).
REQ-002 Ports SHALL be (name, direction, width, meaning): clk, in, 1, the block's single clock; rst_n, in, 1, reset, synchronous and active-low.
REQ-003 sw_snap_req, in, 1, software snapshot request; a single-cycle pulse.
REQ-004 sw_clear_req, in, 1, software live-clear request; a single-cycle pulse.
REQ-005 period_cfg, in, 32, periodic snapshot interval in cycles; 0 disables periodic snapshots.
REQ-006 sa_snapshot, in, [0:NUM_CNT-1][CNT_W-1:0], snapshot values from the stats aggregator core.
REQ-007 sa_snap_o, out, 1, level driven to the core's snap input, which the core edge-detects.
REQ-008 sa_clear_o, out, 1, level driven to the core's clear-live input, which the core edge-detects.
REQ-009 Readout ports SHALL be: rd_valid, out, 1; rd_ready, in, 1; rd_idx, out, 6; rd_data, out, CNT_W; rd_last, out, 1.
REQ-010 Status ports SHALL be: busy, out, 1; snap_done, out, 1 (one-cycle pulse); overrun_cnt, out, 16 (count of dropped snapshot requests).

Function
REQ-011 The FSM SHALL have the states IDLE, CLR, SNAP, SETTLE, STREAM and DONE.
REQ-012 Pending flags: clr_pend, sw_pend and tmr_pend SHALL be set by sw_clear_req, sw_snap_req and timer expiry respectively, in any state.
REQ-013 Each pending flag SHALL be cleared only when its request is granted.
REQ-014 In IDLE the grant priority SHALL be clr_pend > sw_pend > tmr_pend.
REQ-015 A clear grant SHALL enter CLR; a snapshot grant of either type SHALL enter SNAP.
REQ-016 When sw_pend and tmr_pend are both set, one SNAP grant SHALL clear both flags.
REQ-017 CLR SHALL drive sa_clear_o=1 for exactly 2 cycles and then return to IDLE.
REQ-018 SNAP SHALL drive sa_snap_o=1 for exactly 2 cycles and then enter SETTLE.
REQ-019 SETTLE SHALL hold sa_snap_o=0 for SETTLE_CYC cycles and then enter STREAM with rd_idx=0.
REQ-020 At most one of sa_snap_o and sa_clear_o SHALL be high in any cycle.
REQ-021 Each of sa_snap_o and sa_clear_o SHALL be low for at least 1 cycle between assertions.
REQ-022 In STREAM, rd_valid SHALL be 1 and rd_data SHALL equal sa_snapshot[rd_idx].
REQ-023 rd_idx, rd_data and rd_last SHALL remain stable while rd_valid=1 and rd_ready=0.
REQ-024 Each cycle with rd_valid and rd_ready both high SHALL be one transfer.
REQ-025 On a transfer with rd_idx < NUM_CNT-1, rd_idx SHALL increment by 1.
REQ-026 rd_last SHALL equal (rd_idx==NUM_CNT-1).
REQ-027 A transfer with rd_last=1 SHALL enter DONE.
REQ-028 In DONE, snap_done SHALL be 1 for one cycle, then the FSM SHALL return to IDLE.
REQ-029 A back-to-back grant from IDLE SHALL be allowed on the cycle after the return.
REQ-030 busy SHALL be 1 in every state other than IDLE.
REQ-031 Timer: while period_cfg != 0, a 32-bit down-counter SHALL decrement every cycle.
REQ-032 At 0 the timer SHALL set tmr_pend and reload period_cfg-1.
REQ-033 With period_cfg=1 the timer SHALL expire every cycle.
REQ-034 A change of period_cfg (compared with its registered copy) SHALL reload the timer to period_cfg-1 without expiring.
REQ-035 period_cfg=0 SHALL hold the timer at 0 and SHALL NOT set tmr_pend.
REQ-036 Overrun: a snapshot request (sw or timer) arriving while its own pending flag is already 1 SHALL increment overrun_cnt, saturating at 16'hFFFF.
REQ-037 Simultaneous sw and timer requests with both flags clear SHALL NOT count as an overrun.
REQ-038 sw_clear_req with clr_pend=1 SHALL be merged and SHALL NOT count as an overrun.
REQ-039 A request arriving on the same cycle as the grant of that flag SHALL re-set the flag and SHALL NOT count as an overrun.
REQ-040 All outputs SHALL be registered, except rd_data, which MAY be a combinational mux on a registered rd_idx.

Reset
REQ-041 rst_n=0 at a rising clk edge SHALL force: state=IDLE; all pending flags=0; timer=0; period_cfg copy=0; overrun_cnt=0; rd_idx=0.
REQ-042 rst_n=0 SHALL also force sa_snap_o=0, sa_clear_o=0, rd_valid=0, rd_last=0, busy=0 and snap_done=0.
REQ-043 Reset asserted mid-STREAM or mid-SNAP SHALL abandon the operation with no snap_done pulse; requests presented in reset cycles are ignored.
REQ-044 Reset SHALL take effect only on clock edges; there SHALL be no asynchronous path.

Verification
REQ-045 sw_snap_req pulse at cycle 0 with rd_ready=1 -> sa_snap_o high for 2 cycles; rd_valid after SETTLE_CYC=4 cycles; 64 transfers with rd_idx 0..63 and rd_data equal to sa_snapshot[i]; rd_last only on idx 63; then a one-cycle snap_done.
REQ-046 Scenario: rd_ready toggled pseudo-randomly during STREAM -> no index skipped or repeated; outputs stable during stalls.
REQ-047 Scenario: period_cfg=100 -> tmr_pend every 100 cycles.
REQ-048 Scenario: period_cfg=100 with rd_ready held 0 for 300 cycles -> overrun_cnt=2 after the stream completes, and exactly one further snapshot is serviced.
REQ-049 Scenario: sw_clear_req and sw_snap_req in the same cycle in IDLE -> CLR (sa_clear_o 2 cycles), then SNAP; sa_snap_o and sa_clear_o never high together.
REQ-050 Scenario: rst_n driven low for 1 cycle at rd_idx=30 -> all outputs return to their reset values on the next edge, no snap_done, and a subsequent sw_snap_req restarts the stream at rd_idx=0.
